// File: rtl/axi_lite_cmd_master.sv
// Queued AXI4-Lite master: a command FIFO feeds a single-outstanding AXI4-Lite engine that
// returns one response per command, with a per-handshake bus-hang timeout.
module axi_lite_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned TIMEOUT    = 256,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned PTR_W      = $clog2(CMD_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // command port
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [STRB_WIDTH-1:0] i_cmd_wstrb,
    output logic [PTR_W:0]        o_cmd_count,
    // response port
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_write,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_rsp_timeout,
    // AXI4-Lite write channels
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0] o_wstrb,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    // AXI4-Lite read channels
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rvalid,
    output logic                  o_rready
);

    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StWrAddr, StWrResp, StRdAddr, StRdData, StResp
    } state_e;

    // command FIFO
    logic                  r_fifo_write [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_addr  [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_wdata [CMD_DEPTH];
    logic [STRB_WIDTH-1:0] r_fifo_wstrb [CMD_DEPTH];
    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;

    logic [PTR_W:0]        w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_write;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_wdata;
    logic [STRB_WIDTH-1:0] w_head_wstrb;

    // transaction engine
    state_e                r_state;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic                  r_rsp_write;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic                  r_rsp_timeout;

    logic                  w_aw_done;
    logic                  w_w_done;
    logic                  w_in_wait;
    logic                  w_wait_done;
    logic                  w_tmo_hit;

    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_count == (PTR_W+1)'(CMD_DEPTH));
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_push       = i_cmd_valid && !w_full;
    assign w_pop        = (r_state == StIdle) && !w_empty;
    assign w_head_write = r_fifo_write[r_rd_ptr[PTR_W-1:0]];
    assign w_head_addr  = r_fifo_addr[r_rd_ptr[PTR_W-1:0]];
    assign w_head_wdata = r_fifo_wdata[r_rd_ptr[PTR_W-1:0]];
    assign w_head_wstrb = r_fifo_wstrb[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_write[r_wr_ptr[PTR_W-1:0]] <= i_cmd_write;
            r_fifo_addr[r_wr_ptr[PTR_W-1:0]]  <= i_cmd_addr;
            r_fifo_wdata[r_wr_ptr[PTR_W-1:0]] <= i_cmd_wdata;
            r_fifo_wstrb[r_wr_ptr[PTR_W-1:0]] <= i_cmd_wstrb;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // AW and W complete independently; a channel already handshaken counts as done
    assign w_aw_done = !r_awvalid || i_awready;
    assign w_w_done  = !r_wvalid || i_wready;
    assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_comb begin
        w_in_wait   = 1'b1;
        w_wait_done = 1'b0;
        unique case (r_state)
            StWrAddr: w_wait_done = w_aw_done && w_w_done;
            StWrResp: w_wait_done = i_bvalid;
            StRdAddr: w_wait_done = i_arready;
            StRdData: w_wait_done = i_rvalid;
            default:  w_in_wait   = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_tmo_cnt     <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_addr      <= w_head_addr;
                        r_wdata     <= w_head_wdata;
                        r_wstrb     <= w_head_wstrb;
                        r_rsp_write <= w_head_write;
                        r_tmo_cnt   <= '0;
                        if (w_head_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= StWrAddr;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= StRdAddr;
                        end
                    end
                end
                StWrAddr: begin
                    if (i_awready) r_awvalid <= 1'b0;
                    if (i_wready)  r_wvalid  <= 1'b0;
                    if (w_wait_done) begin
                        r_bready  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (i_bvalid) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_resp    <= i_bresp;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= StResp;
                    end
                end
                StRdAddr: begin
                    if (i_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= StRdData;
                    end
                end
                StRdData: begin
                    if (i_rvalid) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_resp    <= i_rresp;
                        r_rsp_rdata   <= i_rdata;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= StResp;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Abort overrides the per-state updates above; a handshake on the last cycle wins.
            if (w_in_wait && !w_wait_done) begin
                if (w_tmo_hit) begin
                    r_awvalid     <= 1'b0;
                    r_wvalid      <= 1'b0;
                    r_bready      <= 1'b0;
                    r_arvalid     <= 1'b0;
                    r_rready      <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_resp    <= 2'b10;
                    r_rsp_rdata   <= '0;
                    r_rsp_timeout <= 1'b1;
                    r_state       <= StResp;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
            end
        end
    end

    assign o_cmd_ready   = !w_full;
    assign o_cmd_count   = w_count;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_write   = r_rsp_write;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_resp    = r_rsp_resp;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_awaddr      = r_addr;
    assign o_awvalid     = r_awvalid;
    assign o_wdata       = r_wdata;
    assign o_wstrb       = r_wstrb;
    assign o_wvalid      = r_wvalid;
    assign o_bready      = r_bready;
    assign o_araddr      = r_addr;
    assign o_arvalid     = r_arvalid;
    assign o_rready      = r_rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Scoreboard bench for axi_lite_cmd_master: a delay-configurable AXI4-Lite slave with its own
// memory, and expected AXI addresses/data/responses queued when each command is accepted.
module tb_axi_lite_cmd_master;

    localparam int unsigned AW = 32, DW = 32, SW = 4, DEPTH = 4, TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic [2:0]    cmd_count;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_cmd_count(cmd_count),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
        .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
        .o_awaddr(awaddr), .o_awvalid(awvalid), .i_awready(awready),
        .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
        .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
        .o_araddr(araddr), .o_arvalid(arvalid), .i_arready(arready),
        .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready)
    );

    typedef struct packed { logic wr; logic [31:0] addr; } addr_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } wdat_t;
    typedef struct packed { logic wr; logic [31:0] rdata; logic [1:0] resp; logic tmo; } rsp_t;

    addr_t       exp_addr_q[$];
    wdat_t       exp_w_q[$];
    rsp_t        exp_rsp_q[$];
    logic [31:0] s_aw_q[$];
    wdat_t       s_w_q[$];
    logic [31:0] s_ar_q[$];
    logic [31:0] ref_mem   [16];
    logic [31:0] slave_mem [16];

    int n_checks = 0;
    int n_errors = 0;

    int          cfg_aw_delay, cfg_w_delay, cfg_b_delay, cfg_ar_delay, cfg_r_delay;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic        rsp_stall;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        b_done, r_done;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] merge_strb(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Slave + response sink. Ready is raised at a negedge while valid is high, so the
    // handshake is committed for the next rising edge and checked here.
    initial begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rsp_ready = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; b_done = 0; r_done = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                b_done = 0; r_done = 0;
                s_aw_q.delete(); s_w_q.delete(); s_ar_q.delete();
            end else begin
                if (b_done) begin bvalid = 0; b_done = 0; end
                if (!bvalid && s_aw_q.size() != 0 && s_w_q.size() != 0) begin
                    if (b_cnt >= cfg_b_delay) begin
                        logic [31:0] a;
                        wdat_t       w;
                        a = s_aw_q.pop_front();
                        w = s_w_q.pop_front();
                        slave_mem[a[5:2]] = merge_strb(slave_mem[a[5:2]], w.data, w.strb);
                        bvalid = 1; bresp = cfg_bresp; b_cnt = 0;
                    end else b_cnt++;
                end
                if (bvalid && bready) b_done = 1;

                if (r_done) begin rvalid = 0; r_done = 0; end
                if (!rvalid && s_ar_q.size() != 0) begin
                    if (r_cnt >= cfg_r_delay) begin
                        logic [31:0] a;
                        a = s_ar_q.pop_front();
                        rdata = slave_mem[a[5:2]]; rresp = cfg_rresp; rvalid = 1; r_cnt = 0;
                    end else r_cnt++;
                end
                if (rvalid && rready) r_done = 1;

                awready = 0;
                if (awvalid) begin
                    if (aw_cnt >= cfg_aw_delay) begin
                        awready = 1; aw_cnt = 0; s_aw_q.push_back(awaddr);
                        check_eq("aw_expected", 64'(exp_addr_q.size() != 0), 64'd1);
                        if (exp_addr_q.size() != 0) begin
                            addr_t e;
                            e = exp_addr_q.pop_front();
                            check_eq("aw_order_kind", 64'(e.wr), 64'd1);
                            check_eq("aw_addr", 64'(awaddr), 64'(e.addr));
                        end
                    end else aw_cnt++;
                end else aw_cnt = 0;

                wready = 0;
                if (wvalid) begin
                    if (w_cnt >= cfg_w_delay) begin
                        wready = 1; w_cnt = 0; s_w_q.push_back({wdata, wstrb});
                        check_eq("w_expected", 64'(exp_w_q.size() != 0), 64'd1);
                        if (exp_w_q.size() != 0) begin
                            wdat_t e;
                            e = exp_w_q.pop_front();
                            check_eq("w_data", 64'(wdata), 64'(e.data));
                            check_eq("w_strb", 64'(wstrb), 64'(e.strb));
                        end
                    end else w_cnt++;
                end else w_cnt = 0;

                arready = 0;
                if (arvalid) begin
                    if (ar_cnt >= cfg_ar_delay) begin
                        arready = 1; ar_cnt = 0; s_ar_q.push_back(araddr);
                        check_eq("ar_expected", 64'(exp_addr_q.size() != 0), 64'd1);
                        if (exp_addr_q.size() != 0) begin
                            addr_t e;
                            e = exp_addr_q.pop_front();
                            check_eq("ar_order_kind", 64'(e.wr), 64'd0);
                            check_eq("ar_addr", 64'(araddr), 64'(e.addr));
                        end
                    end else ar_cnt++;
                end else ar_cnt = 0;
            end

            rsp_ready = !rsp_stall;
            if (rsp_valid && rsp_ready) begin
                check_eq("rsp_expected", 64'(exp_rsp_q.size() != 0), 64'd1);
                if (exp_rsp_q.size() != 0) begin
                    rsp_t e;
                    e = exp_rsp_q.pop_front();
                    check_eq("rsp_write", 64'(rsp_write), 64'(e.wr));
                    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check_eq("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    check_eq("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                end
            end
        end
    end

    // mode 0: normal, 1: read expected to time out, 2: abandoned by reset (no expectations)
    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int mode);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        for (int k = 0; k < 300 && !cmd_ready; k++) @(negedge clk);
        if (!cmd_ready) begin
            check_eq("cmd_ready_wait", 64'(cmd_ready), 64'd1);
            cmd_valid = 0;
            return;
        end
        @(posedge clk);
        if (mode == 0) begin
            exp_addr_q.push_back('{wr: wr, addr: addr});
            if (wr) begin
                exp_w_q.push_back('{data: data, strb: strb});
                ref_mem[addr[5:2]] = merge_strb(ref_mem[addr[5:2]], data, strb);
                exp_rsp_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: cfg_bresp, tmo: 1'b0});
            end else begin
                exp_rsp_q.push_back('{wr: 1'b0, rdata: ref_mem[addr[5:2]], resp: cfg_rresp,
                                      tmo: 1'b0});
            end
        end else if (mode == 1) begin
            exp_rsp_q.push_back('{wr: 1'b0, rdata: 32'h0, resp: 2'b10, tmo: 1'b1});
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 600; k++) begin
            if (exp_rsp_q.size() == 0 && !rsp_valid && cmd_count == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_eq("drain_rsp", 64'(exp_rsp_q.size()), 64'd0);
        check_eq("drain_addr", 64'(exp_addr_q.size()), 64'd0);
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        cfg_aw_delay = aw; cfg_w_delay = w; cfg_b_delay = b; cfg_ar_delay = ar; cfg_r_delay = r;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        for (int i = 0; i < 16; i++) begin ref_mem[i] = 0; slave_mem[i] = 0; end
        set_delays(0, 0, 0, 0, 0);
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; rsp_stall = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_cmd_count", 64'(cmd_count), 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        rst = 0;

        // T1: write, wready three cycles late, plus N+2 latency
        set_delays(0, 3, 0, 0, 0);
        push_cmd(1, 32'h4, 32'hDEADBEEF, 4'hF, 0);
        check_eq("t1_count_n1", 64'(cmd_count), 64'd1);
        check_eq("t1_awvalid_n1", 64'(awvalid), 64'd0);
        @(negedge clk);
        check_eq("t1_awvalid_n2", 64'(awvalid), 64'd1);
        check_eq("t1_wvalid_n2", 64'(wvalid), 64'd1);
        wait_idle();

        // T2: read back
        set_delays(0, 0, 2, 1, 2);
        push_cmd(0, 32'h4, 32'h0, 4'h0, 0);
        wait_idle();

        // T3: FIFO fills behind a stalled slave; order preserved
        set_delays(10, 2, 1, 10, 1);
        push_cmd(1, 32'h10, 32'hA5A5A5A5, 4'hF, 0);
        push_cmd(0, 32'h10, 32'h0, 4'h0, 0);
        push_cmd(1, 32'h14, 32'h12345678, 4'hC, 0);
        push_cmd(0, 32'h14, 32'h0, 4'h0, 0);
        push_cmd(0, 32'h4, 32'h0, 4'h0, 0);
        check_eq("t3_count_full", 64'(cmd_count), 64'd4);
        check_eq("t3_cmd_ready_full", 64'(cmd_ready), 64'd0);
        wait_idle();

        // T4: slave error responses
        set_delays(1, 0, 0, 0, 0);
        cfg_bresp = 2'b10; cfg_rresp = 2'b10;
        push_cmd(1, 32'h18, 32'h0BADF00D, 4'h3, 0);
        push_cmd(0, 32'h18, 32'h0, 4'h0, 0);
        wait_idle();
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;

        // T5: arready never arrives
        set_delays(0, 0, 0, 1000, 0);
        push_cmd(0, 32'h4, 32'h0, 4'h0, 1);
        for (int k = 0; k < 20 && !arvalid; k++) @(negedge clk);
        len = 0;
        while (arvalid && len < 100) begin len++; @(negedge clk); end
        check_eq("t5_arvalid_cycles", 64'(len), 64'(TMO));
        wait_idle();

        // T6a: response held off; fields stable, no AXI activity
        set_delays(0, 0, 0, 0, 0);
        rsp_stall = 1;
        push_cmd(0, 32'h4, 32'h0, 4'h0, 0);
        for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
        push_cmd(1, 32'h20, 32'hCAFEF00D, 4'hF, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t6_rsp_valid", 64'(rsp_valid), 64'd1);
            check_eq("t6_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
            check_eq("t6_rsp_write", 64'(rsp_write), 64'd0);
            check_eq("t6_no_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
            check_eq("t6_count", 64'(cmd_count), 64'd1);
        end
        rsp_stall = 0;
        wait_idle();

        // T6b: reset while waiting in the write-address phase
        set_delays(100, 100, 0, 0, 0);
        push_cmd(1, 32'h30, 32'h55555555, 4'hF, 2);
        for (int k = 0; k < 20 && !awvalid; k++) @(negedge clk);
        push_cmd(0, 32'h30, 32'h0, 4'h0, 2);
        check_eq("t6_pre_rst_count", 64'(cmd_count), 64'd1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check_eq("t6_rst_rsp", 64'({rsp_valid, rsp_write, rsp_timeout}), 64'd0);
        check_eq("t6_rst_count", 64'(cmd_count), 64'd0);
        rst = 0;

        // recovery with a partial-strobe write
        set_delays(0, 1, 0, 0, 0);
        push_cmd(1, 32'h8, 32'h11223344, 4'h5, 0);
        push_cmd(0, 32'h8, 32'h0, 4'h0, 0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
